// File: rtl/rgb_pkg.sv
// Pixel types and reader FSM states shared by the RGB frame RAM, source and reader stages.
package rgb_pkg;

    localparam int RGB_DW = 8;

    typedef struct packed {
        logic [RGB_DW-1:0] r;
        logic [RGB_DW-1:0] g;
        logic [RGB_DW-1:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t pix;
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rgb_frame_reader_if.sv
// Valid/ready pixel stream with frame markers leaving the frame reader.
interface rgb_frame_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_R;
    logic [DATA_WIDTH-1:0] out_G;
    logic [DATA_WIDTH-1:0] out_B;
    logic                  out_sof;
    logic                  out_eol;
    logic                  out_eof;

    modport master (
        output out_valid, out_R, out_G, out_B, out_sof, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_R, out_G, out_B, out_sof, out_eol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/rgb_frame_reader_skid_buf.sv
// Two-entry valid/ready FIFO of tagged pixels; occupancy is exported for read credit.
module pix_skid_buf
    import rgb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  pix_tag_t   i_data,
    input  logic       i_pop,
    output pix_tag_t   o_head,
    output logic       o_valid,
    output logic [1:0] o_occ
);
    pix_tag_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_occ   = r_count;
endmodule

// File: rtl/rgb_frame_reader.sv
// Raster-scan reader: walks one frame of RAM addresses and streams tagged pixels
// behind the RAM's one-cycle read latency.
module rgb_frame_reader
    import rgb_pkg::*;
#(
    parameter int DATA_WIDTH = RGB_DW,
    parameter int ADD_WIDTH  = 12,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADD_WIDTH-1:0]  address_read,
    input  logic [DATA_WIDTH-1:0] data_r_R,
    input  logic [DATA_WIDTH-1:0] data_r_G,
    input  logic [DATA_WIDTH-1:0] data_r_B,
    rgb_frame_reader_if.master    pix,
    output logic                  busy,
    output logic                  done
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(NPIX - 1);
    localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(IMG_W - 1);

    rd_state_t      r_state;
    rd_state_t      w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic           r_all_issued;
    logic           r_inflight;
    logic           r_sof_p0;
    logic           r_eol_p0;
    logic           r_eof_p0;
    logic           w_issue;
    logic           w_pop;
    logic           w_head_vld;
    logic [1:0]     w_occ;
    logic [2:0]     w_load;
    pix_tag_t       w_push_data;
    pix_tag_t       w_head;

    // Buffer slots already spoken for after this cycle's pop; a new read needs one free.
    assign w_pop   = w_head_vld && pix.out_ready;
    assign w_load  = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == ST_RUN) && !r_all_issued && (w_load < 3'd2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_all_issued && !r_inflight && (w_load == 3'd0)) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            address_read <= '0;
            r_col        <= '0;
            r_all_issued <= 1'b0;
            r_inflight   <= 1'b0;
            r_sof_p0     <= 1'b0;
            r_eol_p0     <= 1'b0;
            r_eof_p0     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_sof_p0 <= (address_read == '0);
                r_eol_p0 <= (r_col == LAST_COL);
                r_eof_p0 <= (address_read == LAST_ADDR);
            end
            if ((r_state == ST_IDLE) && start) begin
                address_read <= '0;
                r_col        <= '0;
                r_all_issued <= 1'b0;
            end else if (w_issue) begin
                if (address_read == LAST_ADDR) r_all_issued <= 1'b1;
                else                           address_read <= address_read + ADD_WIDTH'(1);
                r_col <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
            end
        end
    end

    // RAM data lands one cycle after its address; tags ride along from issue time.
    always_comb begin
        w_push_data.pix.r = data_r_R;
        w_push_data.pix.g = data_r_G;
        w_push_data.pix.b = data_r_B;
        w_push_data.sof   = r_sof_p0;
        w_push_data.eol   = r_eol_p0;
        w_push_data.eof   = r_eof_p0;
    end

    pix_skid_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_head_vld),
        .o_occ   (w_occ)
    );

    assign pix.out_valid = w_head_vld;
    assign pix.out_R     = w_head.pix.r;
    assign pix.out_G     = w_head.pix.g;
    assign pix.out_B     = w_head.pix.b;
    assign pix.out_sof   = w_head.sof;
    assign pix.out_eol   = w_head.eol;
    assign pix.out_eof   = w_head.eof;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
endmodule

// File: doc/rgb_frame_reader.md
# rgb_frame_reader

Raster-scan read sequencer that sits directly downstream of the dual-clock RGB frame RAM read port. On a start pulse it walks every address of one IMG_W x IMG_H frame, absorbs the RAM's one-cycle read latency, and emits a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers. It feeds display, processing or dump stages. Throughput is one pixel per clock when the sink never stalls.

## Interface
- DATA_WIDTH, 8, bits per colour channel
- ADD_WIDTH, 12, RAM address width; must satisfy 2^ADD_WIDTH >= IMG_W*IMG_H
- IMG_W, 64, pixels per line
- IMG_H, 64, lines per frame

Ports:
- clk  in  1  single clock; the RAM read clock (clk_read) is tied to it
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to stream one frame; sampled only in IDLE
- address_read  out  ADD_WIDTH  RAM read address, registered
- data_r_R / data_r_G / data_r_B  in  DATA_WIDTH each  RAM read data, valid one cycle after its address
- out_valid  out  1  pixel available
- out_ready  in  1  sink accepts pixel
- out_R / out_G / out_B  out  DATA_WIDTH each  pixel data
- out_sof  out  1  qualifies pixel 0
- out_eol  out  1  qualifies the last pixel of each line
- out_eof  out  1  qualifies the last pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final handshake

## Operation
- Handshake: a transfer occurs on a clock edge where out_valid && out_ready. While out_valid=1 and out_ready=0, the data and marker outputs hold stable. out_valid never drops without a transfer.
- FSM states:
  - IDLE: waits for start. On start, goes to RUN and clears the address and line counters.
  - RUN: issues reads at address_read = 0 .. IMG_W*IMG_H-1 in linear order, one per cycle, when credit allows. After the last address is issued and the buffer has drained, goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Credit rule: a read is issued in cycle t only if (buffer occupancy − pops in t + reads in flight) < 2. A read returns in t+1 and is pushed into a 2-entry pixel buffer. The buffer head drives out_*.
- Markers are tagged at issue time and travel with the pixel:
  - sof when the linear index is 0
  - eol when the column counter is IMG_W-1
  - eof when the index is IMG_W*IMG_H-1
- The column counter wraps to 0 after IMG_W-1. The index does not wrap; no read is issued past the last pixel.
- start in RUN or DONE is ignored; it is not queued.
- busy=1 in RUN and DONE.

## Timing
- Reset values: address_read=0, out_valid=0, out_R/G/B=0, markers=0, busy=0, done=0; FSM in IDLE; buffer empty; nothing in flight.
- start sampled at edge 0 → address 0 issued in cycle 1 → RAM data in cycle 2 → out_valid=1 from cycle 3, carrying pixel 0 with sof=1.
- With out_ready held at 1: pixels 0..N-1 (N=IMG_W*IMG_H) are accepted on consecutive cycles 3..N+2, and done=1 in cycle N+3.
- Under stalls the buffer never overflows. A read returning while the buffer is full is impossible by the credit rule; the bench asserts this.
- rst asserted mid-frame clears all state immediately (asynchronously), with no done pulse. Data for a read still in flight is discarded.
- A fresh start is accepted in the cycle after done.

## Structure
- Shared package rgb_pkg holds the rgb_t struct of three DATA_WIDTH channels, the pix_tag_t struct of rgb_t plus the sof/eol/eof bits, and the reader FSM state enum. The package is shared with the RAM and source stages.
- Sub-module pix_skid_buf: 2-entry valid/ready FIFO of pix_tag_t. It exposes its occupancy for the credit logic.
- Top level holds the FSM, the address/column counters, and the in-flight flag.

## Test plan
- RAM model preloaded with R=addr[7:0], G=~addr[7:0], B={addr[11:8],4'h0}; out_ready=1; start → exactly 4096 pixels in address order, first valid in cycle 3, done in cycle 4099.
- out_ready random at 50% → pixel sequence identical to the previous case, no drops or duplicates, outputs stable during stalls, buffer never overflows.
- IMG_W=4, IMG_H=2 → eol on pixels 3 and 7, sof on pixel 0 only, eof on pixel 7 only.
- out_ready=0 for 20 cycles after the first valid → address_read advances at most 2 beyond the head pixel, then streaming resumes losslessly.
- start pulsed at pixel 100 of a frame → ignored; exactly one frame and one done pulse.
- rst asserted at pixel 1000, released, then start → outputs at reset values during rst; the new frame restarts at address 0 with sof=1.
